// File: rtl/edge_detector_pkg.sv
// Shared definitions for the edge detector family: default parameters and
// the debounce counter width helper.
package edge_detector_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE    = 4;

  // Counter must hold values 0..debounce-1; one spare code keeps debounce=1 legal.
  function automatic int unsigned cnt_w(input int unsigned debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One edge detector channel: input synchroniser, debounce counter,
// accepted level and registered rise/fall pulses.
module edge_filter_ch
  import edge_detector_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned          CNT_W   = cnt_w(DEBOUNCE);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift chain; the cast drops the oldest sample off the top.
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= SYNC_STAGES'({sync_q, sig});
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Accept a new level only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel debounced edge detector with aggregate event flag.
// Optional sticky event flags enabled by EDGE_DETECTOR_BANK_STICKY_EN.
module edge_detector_bank
  import edge_detector_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any
`ifdef EDGE_DETECTOR_BANK_STICKY_EN
  ,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] sticky_rise,
  output logic [WIDTH-1:0] sticky_fall
`endif
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      edge_filter_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .sig   (sig[i]),
        .level (level[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) any <= 1'b0;
    else     any <= |(rise | fall);
  end

`ifdef EDGE_DETECTOR_BANK_STICKY_EN
  // Set has priority over clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_rise <= '0;
      sticky_fall <= '0;
    end else begin
      sticky_rise <= (sticky_rise & ~clr) | rise;
      sticky_fall <= (sticky_fall & ~clr) | fall;
    end
  end
`endif

endmodule

// File: tb/tb_edge_detector_bank.sv
// Directed bench for edge_detector_bank (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3).
// Sticky checks run when EDGE_DETECTOR_BANK_STICKY_EN is defined.
module tb_edge_detector_bank;

  logic       clk;
  logic       rst;
  logic [3:0] sig;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any;
`ifdef EDGE_DETECTOR_BANK_STICKY_EN
  logic [3:0] clr;
  logic [3:0] sticky_rise;
  logic [3:0] sticky_fall;
`endif

  int checks = 0;
  int errors = 0;

  edge_detector_bank #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .DEBOUNCE    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig         (sig),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .any         (any)
`ifdef EDGE_DETECTOR_BANK_STICKY_EN
    ,
    .clr         (clr),
    .sticky_rise (sticky_rise),
    .sticky_fall (sticky_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sig = 4'hF;
`ifdef EDGE_DETECTOR_BANK_STICKY_EN
    clr = 4'h0;
`endif

    // Reset with inputs high, then release: rise on all channels 5 edges later
    tick(3);
    check("rst_level", level, 4'h0);
    check("rst_rise",  rise,  4'h0);
    check("rst_fall",  fall,  4'h0);
    check("rst_any",   {3'b0, any}, 4'h0);
    rst = 1'b0;
    tick(4);
    check("rel_rise_early",  rise,  4'h0);
    check("rel_level_early", level, 4'h0);
    tick(1);
    check("rel_rise",  rise,  4'hF);
    check("rel_level", level, 4'hF);
    tick(1);
    check("rel_rise_once", rise, 4'h0);
    check("rel_any",       {3'b0, any}, 4'h1);
    tick(1);
    check("rel_any_once",  {3'b0, any}, 4'h0);

    // Drop channels 0,1,3; keep channel 2 high
    sig = 4'b0100;
    tick(4);
    check("fall_early", fall, 4'h0);
    tick(1);
    check("fall_pulse", fall,  4'b1011);
    check("fall_rise",  rise,  4'h0);
    check("fall_level", level, 4'b0100);
    tick(1);
    check("fall_once", fall, 4'h0);
    check("fall_any",  {3'b0, any}, 4'h1);

    // Single channel rise
    sig = 4'b0101;
    tick(4);
    check("r0_early", rise, 4'h0);
    tick(1);
    check("r0_rise",  rise,  4'b0001);
    check("r0_level", level, 4'b0101);
    tick(1);
    check("r0_once",  rise,  4'h0);
    check("r0_any",   {3'b0, any}, 4'h1);
    check("r0_hold",  level, 4'b0101);
    tick(3);
    check("r0_hold2", level, 4'b0101);

    // Two-cycle glitch on channel 1 must be rejected
    sig = 4'b0111;
    tick(2);
    sig = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      check("glitch_rise",  rise,  4'h0);
      check("glitch_fall",  fall,  4'h0);
      check("glitch_level", level, 4'b0101);
      tick(1);
    end

    // Simultaneous rises on 0 and 3 with a fall on settled channel 2
    sig = 4'b0100;
    tick(8);
    check("sim_prep_level", level, 4'b0100);
    sig = 4'b1001;
    tick(4);
    check("sim_rise_early", rise, 4'h0);
    check("sim_fall_early", fall, 4'h0);
    tick(1);
    check("sim_rise",  rise,  4'b1001);
    check("sim_fall",  fall,  4'b0100);
    check("sim_level", level, 4'b1001);
    tick(1);
    check("sim_any",   {3'b0, any}, 4'h1);
    check("sim_clear", rise | fall, 4'h0);

    // Reset mid-count on channel 2 discards the count and emits nothing
    sig = 4'b1101;
    tick(3);
    check("mid_rise_none", rise, 4'h0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_level", level, 4'h0);
    check("mid_rst_rise",  rise,  4'h0);
    check("mid_rst_fall",  fall,  4'h0);
    check("mid_rst_any",   {3'b0, any}, 4'h0);
    tick(4);
    check("post_rise_early", rise, 4'h0);
    check("post_fall_none",  fall, 4'h0);
    tick(1);
    check("post_rise",  rise,  4'b1101);
    check("post_level", level, 4'b1101);

`ifdef EDGE_DETECTOR_BANK_STICKY_EN
    // Sticky set, clear alone, then clear coincident with a new rise
    tick(1);
    check("st_initial", sticky_rise, 4'b1101);
    sig = 4'b1111;
    tick(5);
    check("st_r1_pulse", rise, 4'b0010);
    tick(1);
    check("st_set", sticky_rise, 4'b1111);
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    check("st_clr", sticky_rise, 4'b1101);
    sig = 4'b1101;
    tick(8);
    check("st_fall_set", sticky_fall, 4'b0010);
    sig = 4'b1111;
    tick(5);
    check("st_r1_again", rise, 4'b0010);
    check("st_pre",      sticky_rise, 4'b1101);
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    check("st_set_wins", sticky_rise, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Parametrised multi-channel edge detector with a per-channel input synchroniser and a debounce (glitch) filter. It produces a registered filtered level plus one-cycle rise and fall pulses per channel, and an aggregate event flag. It sits between raw asynchronous inputs (buttons, external strobes, status lines) and synchronous control logic. It is the generalised successor of the single-bit `edge_detector`.

## Interface
Parameters:
- `WIDTH`, 8: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel. 0 means `sig` is used directly.
- `DEBOUNCE`, 4: consecutive differing samples required to accept a new level, ≥1. 1 means no filtering.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sig`  in  WIDTH  raw inputs, may be asynchronous.
- `level`  out  WIDTH  filtered, accepted level per channel.
- `rise`  out  WIDTH  one-cycle pulse on an accepted 0→1 change.
- `fall`  out  WIDTH  one-cycle pulse on an accepted 1→0 change.
- `any`  out  1  registered OR of all bits of `rise | fall`.
- `clr`  in  WIDTH  sticky clear. Present only with `EDGE_DETECTOR_BANK_STICKY_EN`.
- `sticky_rise`, `sticky_fall`  out  WIDTH  latched events. Present only with the macro.

## Operation
- **Reset.** While `rst`=1 at a clock edge, the following are all cleared to 0: synchroniser flops, counters, `level`, `rise`, `fall`, `any`, and the sticky flags.
- **Synchroniser.** `s[i]` is the last flop of an `SYNC_STAGES`-deep chain. When `SYNC_STAGES`=0, `s[i]` = `sig[i]`.
- **Filter, per channel.** Each channel has a counter `cnt` of width `$clog2(DEBOUNCE+1)`.
  - If `s[i]` == `level[i]`: `cnt` ← 0.
  - Else if `cnt` == `DEBOUNCE`-1: `level[i]` ← `s[i]`, `cnt` ← 0, and the matching pulse is asserted.
  - Else: `cnt` ← `cnt`+1.
- **Pulses.** `rise[i]` is registered and is high exactly for the cycle in which `level[i]` first shows 1. `fall[i]` behaves the same way for 0. They are never both high on one channel.
- **`any`.** Registered one cycle after the pulses.
- **Glitches.** A difference lasting fewer than `DEBOUNCE` consecutive samples resets `cnt` and produces no pulse.
- **Channel independence.** Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.
- **Behaviour after reset.** `level` restarts at 0. An input held high across reset release therefore produces a `rise` after the full latency. This is intended.

## Timing
- `sig[i]` changes and stays stable before edge E. `level[i]` and `rise[i]`/`fall[i]` are then valid after edge E+`SYNC_STAGES`+`DEBOUNCE`-1.
- Total latency is `SYNC_STAGES`+`DEBOUNCE` edges, counting E itself.
- `any` follows the pulses by one further cycle.
- Minimum accepted pulse width on `sig` is `DEBOUNCE` cycles.
- Minimum spacing between pulses on one channel is `DEBOUNCE` cycles.
- **Reset mid-count.** Reset takes priority over everything. The count in progress is discarded and no pulse is emitted on the reset edge.
- **Counter range.** `cnt` never exceeds `DEBOUNCE`-1, so there is no wrap-around.

## Configuration
- **`EDGE_DETECTOR_BANK_STICKY_EN` defined:**
  - Adds `clr`, `sticky_rise` and `sticky_fall`.
  - `sticky_rise[i]` is set by `rise[i]` and cleared by `clr[i]`.
  - If set and clear occur in the same cycle, set wins (no event is lost).
  - `sticky_fall` behaves the same way with `fall[i]`.
  - Reset clears both sticky vectors.
- **Macro undefined:** those ports and registers do not exist. All other behaviour is identical.

## Structure
- **Package `edge_detector_pkg`:**
  - `cnt_w(debounce)` width function.
  - Default-parameter localparams, shared with the single-bit detector.
- **Sub-module `edge_filter_ch`:** one channel (synchroniser, counter, level, rise/fall), instantiated `WIDTH` times in a generate loop.
- **Top level:** holds `any` and the optional sticky logic.

## Test plan
All scenarios use `WIDTH`=4, `SYNC_STAGES`=2, `DEBOUNCE`=3.
1. `rst`=1 for 3 cycles with `sig`=4'hF → all outputs 0. Release reset → `rise`=4'hF pulses once, 5 edges later.
2. `sig[0]` 0→1 held → `rise[0]`=1 for exactly one cycle at edge +5, `level[0]`=1 from then on, `any`=1 at edge +6.
3. `sig[1]` high for 2 cycles, then low → `rise`, `fall` and `level[1]` stay 0 throughout.
4. `sig[0]` and `sig[3]` rise on the same edge while `sig[2]` (high, settled) falls → `rise`=4'b1001 and `fall`=4'b0100 in the same cycle.
5. `sig[2]` rises, and `rst` pulses 1 cycle after 3 edges → no pulse. With `sig[2]` held high, `rise[2]` occurs 5 edges after release.
6. Sticky build only:
   - a `rise[1]` sets `sticky_rise[1]`;
   - `clr[1]` alone clears it on the next edge;
   - `clr[1]` coincident with a new `rise[1]` leaves it 1.
